// File: rtl/multdiv_cycle_counter_if.sv
// Handshake bundle between the multdiv controller/datapath (master) and the
// cycle counter (slave).
interface multdiv_cycle_counter_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             mode;
    logic             last;
    logic             done;

    modport master (
        output en, start_mult, start_div,
        input  count, busy, mode, last, done
    );

    modport slave (
        input  en, start_mult, start_div,
        output count, busy, mode, last, done
    );
endinterface

// File: rtl/multdiv_cycle_counter.sv
// Cycle sequencer for the multicycle multiply/divide unit: a synchronous counter
// with a per-operation terminal count, abortable restart and a one-cycle done pulse.
module multdiv_cycle_counter #(
    parameter int WIDTH       = 6,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 33
) (
    input  logic                   clk,
    input  logic                   clr,
    multdiv_cycle_counter_if.slave bus
);
    // Terminal indices are TERM-1, so a TERM of 2^WIDTH still fits in WIDTH bits.
    localparam logic [WIDTH-1:0] MULT_LAST = WIDTH'(MULT_CYCLES - 1);
    localparam logic [WIDTH-1:0] DIV_LAST  = WIDTH'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic             mode, mode_next;
    logic             busy, done;
    logic             start;
    logic             at_term;
    logic [WIDTH-1:0] term_last;

    assign start     = bus.start_mult | bus.start_div;
    assign term_last = mode ? DIV_LAST : MULT_LAST;
    assign at_term   = (count == term_last);

    // A start wins over everything except clr, including a coincident terminal count.
    always_comb begin
        state_next = state;
        count_next = count;
        mode_next  = mode;
        if (start) begin
            state_next = RUN;
            count_next = '0;
            mode_next  = ~bus.start_mult;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                RUN: begin
                    if (bus.en) begin
                        if (at_term) begin
                            state_next = DONE;
                            count_next = '0;
                        end else begin
                            count_next = count + 1'b1;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            count <= '0;
            mode  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            mode  <= mode_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    assign bus.count = count;
    assign bus.busy  = busy;
    assign bus.mode  = mode;
    assign bus.done  = done;
    assign bus.last  = busy & bus.en & at_term;
endmodule

// File: tb/tb_multdiv_cycle_counter.sv
// Directed bench for multdiv_cycle_counter: default instance plus a WIDTH=4,
// MULT_CYCLES=1, DIV_CYCLES=16 instance for the boundary terminal counts.
module tb_multdiv_cycle_counter;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multdiv_cycle_counter_if #(.WIDTH(6)) ifa ();
    multdiv_cycle_counter_if #(.WIDTH(4)) ifb ();

    multdiv_cycle_counter #(.WIDTH(6), .MULT_CYCLES(32), .DIV_CYCLES(33)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (ifa)
    );

    multdiv_cycle_counter #(.WIDTH(4), .MULT_CYCLES(1), .DIV_CYCLES(16)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input int cnt, input bit bsy, input bit md,
                         input bit lst, input bit dn);
        chk({tag, ".count"}, 32'(ifa.count), 32'(cnt));
        chk({tag, ".busy"},  32'(ifa.busy),  32'(bsy));
        chk({tag, ".mode"},  32'(ifa.mode),  32'(md));
        chk({tag, ".last"},  32'(ifa.last),  32'(lst));
        chk({tag, ".done"},  32'(ifa.done),  32'(dn));
    endtask

    initial begin
        clr            = 1'b1;
        ifa.en         = 1'b0;
        ifa.start_mult = 1'b0;
        ifa.start_div  = 1'b0;
        ifb.en         = 1'b0;
        ifb.start_mult = 1'b0;
        ifb.start_div  = 1'b0;

        // Reset, then idle.
        step();
        step();
        chk_a("reset", 0, 0, 0, 0, 0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a("idle", 0, 0, 0, 0, 0);
        end

        // Full multiply: 32 datapath cycles.
        ifa.en         = 1'b1;
        ifa.start_mult = 1'b1;
        step();
        ifa.start_mult = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk_a("mult_run", k, 1, 0, (k == 31), 0);
            step();
        end
        chk_a("mult_done", 0, 0, 0, 0, 1);
        step();
        chk_a("mult_after", 0, 0, 0, 0, 0);

        // Divide with a 3-cycle stall at count 10.
        ifa.start_div = 1'b1;
        step();
        ifa.start_div = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk_a("div_run", k, 1, 1, 0, 0);
            step();
        end
        ifa.en = 1'b0;
        #1;
        chk_a("div_stall_last", 10, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("div_stall", 10, 1, 1, 0, 0);
        end
        ifa.en = 1'b1;
        for (int k = 10; k < 33; k++) begin
            chk_a("div_resume", k, 1, 1, (k == 32), 0);
            step();
        end
        chk_a("div_done", 0, 0, 1, 0, 1);
        step();
        chk_a("div_after", 0, 0, 1, 0, 0);

        // Abort a multiply at count 20 with a divide start.
        ifa.start_mult = 1'b1;
        step();
        ifa.start_mult = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk_a("abort_pre", 20, 1, 0, 0, 0);
        ifa.start_div = 1'b1;
        step();
        ifa.start_div = 1'b0;
        for (int k = 0; k < 33; k++) begin
            chk_a("abort_run", k, 1, 1, (k == 32), 0);
            step();
        end
        chk_a("abort_done", 0, 0, 1, 0, 1);

        // Back-to-back: start on the done cycle, no idle gap.
        ifa.start_div = 1'b1;
        step();
        ifa.start_div = 1'b0;
        chk_a("b2b", 0, 1, 1, 0, 0);
        step();
        chk_a("b2b_next", 1, 1, 1, 0, 0);

        // Simultaneous starts: mult wins.
        ifa.start_mult = 1'b1;
        ifa.start_div  = 1'b1;
        step();
        ifa.start_mult = 1'b0;
        ifa.start_div  = 1'b0;
        chk_a("simul", 0, 1, 0, 0, 0);

        // clr at count 15 together with a start: clr wins, no done follows.
        for (int k = 0; k < 15; k++) step();
        chk_a("clr_pre", 15, 1, 0, 0, 0);
        clr            = 1'b1;
        ifa.start_mult = 1'b1;
        step();
        clr            = 1'b0;
        ifa.start_mult = 1'b0;
        chk_a("clr_mid", 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("clr_nodone", 32'(ifa.done), 32'(0));
            chk("clr_idle", 32'(ifa.busy), 32'(0));
        end

        // WIDTH=4 instance: MULT_CYCLES=1 finishes one edge after start.
        ifb.en         = 1'b1;
        ifb.start_mult = 1'b1;
        #1;
        chk("t1_pre_last", 32'(ifb.last), 32'(0));
        step();
        ifb.start_mult = 1'b0;
        chk("t1_busy",  32'(ifb.busy),  32'(1));
        chk("t1_count", 32'(ifb.count), 32'(0));
        chk("t1_last",  32'(ifb.last),  32'(1));
        chk("t1_done0", 32'(ifb.done),  32'(0));
        step();
        chk("t1_done",  32'(ifb.done),  32'(1));
        chk("t1_idle",  32'(ifb.busy),  32'(0));
        step();
        chk("t1_after", 32'(ifb.done),  32'(0));

        // WIDTH=4 instance: DIV_CYCLES=16 = 2^WIDTH runs to 15 without wrapping.
        ifb.start_div = 1'b1;
        step();
        ifb.start_div = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t16_count", 32'(ifb.count), 32'(k));
            chk("t16_last",  32'(ifb.last),  32'(k == 15));
            chk("t16_done0", 32'(ifb.done),  32'(0));
            step();
        end
        chk("t16_done",  32'(ifb.done),  32'(1));
        chk("t16_mode",  32'(ifb.mode),  32'(1));
        chk("t16_count0", 32'(ifb.count), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
